// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder and its lane alignment logic.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    DWORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } resp_state_t;

  localparam int LANE_BITS = 8;

  // Byte enables for a right-justified access starting at byte lane lo.
  function automatic logic [3:0] byte_en(mem_width_t w, logic [1:0] lo);
    case (w)
      BYTE:    return 4'b0001 << lo;
      WORD:    return 4'b0011 << lo;
      DWORD:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Initiator/responder memory bus between the CPU and the data-memory responder.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic        dispatch_read;
  logic        dispatch_write;
  logic [31:0] addr;
  mem_width_t  mem_width;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy;

  modport master (
    output dispatch_read, dispatch_write, addr, mem_width, write_data,
    input  read_data, busy
  );

  modport slave (
    input  dispatch_read, dispatch_write, addr, mem_width, write_data,
    output read_data, busy
  );

endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational byte-lane steering: store replication/enables and load extraction.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  mem_width_t  wr_width,
  input  logic [1:0]  wr_lo,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_din,
  input  mem_width_t  rd_width,
  input  logic [1:0]  rd_lo,
  input  logic [31:0] rd_dout,
  output logic [31:0] rd_data
);

  always_comb begin
    wr_be = byte_en(wr_width, wr_lo);
    case (wr_width)
      BYTE:    wr_din = {4{wr_data[7:0]}};
      WORD:    wr_din = {2{wr_data[15:0]}};
      default: wr_din = wr_data;
    endcase

    // Loads are zero-extended; sign extension is the CPU's job.
    case (rd_width)
      BYTE:    rd_data = (rd_dout >> (LANE_BITS * rd_lo)) & 32'h0000_00FF;
      WORD:    rd_data = (rd_dout >> (2 * LANE_BITS * rd_lo[1])) & 32'h0000_FFFF;
      default: rd_data = rd_dout;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data bus: services BYTE/WORD/DWORD accesses on a
// single-port BRAM with byte enables, flagging misaligned/out-of-range/protocol errors.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int          DEPTH        = 4096,
  parameter int          READ_LATENCY = 2
)(
  input  logic                     clk_in,
  input  logic                     rst_in,
  data_mem_responder_if.slave      mem_bus,
  output logic [$clog2(DEPTH)-1:0] bram_addr,
  output logic [3:0]               bram_we,
  output logic [31:0]              bram_din,
  input  logic [31:0]              bram_dout,
  output logic                     err_o
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [29:0] BASE_W = ADDR_BASE[31:2];

  resp_state_t state;
  mem_width_t  width_q;
  logic [1:0]  lo_q;
  logic        wr_q, ok_q, err_q;
  logic [1:0]  cnt;
  logic [31:0] read_data_q;

  logic        dispatch, busy_q, in_range, aligned, legal;
  logic [29:0] off_w;
  logic [3:0]  be_c;
  logic [31:0] din_c, rd_c;

  assign dispatch     = mem_bus.dispatch_read | mem_bus.dispatch_write;
  assign busy_q       = (state == ISSUE) || (state == WAIT);
  assign mem_bus.busy = dispatch | busy_q;
  assign mem_bus.read_data = read_data_q;

  // Word offset from the base; any bit above the BRAM index means out of range.
  assign off_w    = mem_bus.addr[31:2] - BASE_W;
  assign in_range = (mem_bus.addr >= ADDR_BASE) && ((off_w >> AW) == '0);

  always_comb begin
    case (mem_bus.mem_width)
      BYTE:    aligned = 1'b1;
      WORD:    aligned = ~mem_bus.addr[0];
      DWORD:   aligned = (mem_bus.addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal = in_range & aligned;

  mem_lane_align u_align (
    .wr_width (mem_bus.mem_width),
    .wr_lo    (mem_bus.addr[1:0]),
    .wr_data  (mem_bus.write_data),
    .wr_be    (be_c),
    .wr_din   (din_c),
    .rd_width (width_q),
    .rd_lo    (lo_q),
    .rd_dout  (bram_dout),
    .rd_data  (rd_c)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      width_q     <= BYTE;
      lo_q        <= '0;
      wr_q        <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt         <= '0;
      read_data_q <= '0;
      bram_addr   <= '0;
      bram_we     <= '0;
      bram_din    <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o   <= 1'b0;
      bram_we <= '0;
      case (state)
        // IDLE and DONE both accept a new dispatch, giving back-to-back issue.
        IDLE, DONE: begin
          if (dispatch) begin
            state   <= ISSUE;
            width_q <= mem_bus.mem_width;
            lo_q    <= mem_bus.addr[1:0];
            wr_q    <= mem_bus.dispatch_write;
            ok_q    <= legal;
            err_q   <= ~legal | (mem_bus.dispatch_read & mem_bus.dispatch_write);
            if (legal) bram_addr <= off_w[AW-1:0];
            if (legal && mem_bus.dispatch_write) begin
              bram_we  <= be_c;
              bram_din <= din_c;
            end
          end else begin
            state <= IDLE;
          end
        end
        // Errors also pass through ISSUE so their busy timing matches a write.
        ISSUE: begin
          if (ok_q && !wr_q) begin
            cnt   <= 2'(READ_LATENCY - 1);
            state <= WAIT;
          end else begin
            state <= DONE;
            err_o <= err_q;
            if (!wr_q) read_data_q <= '0;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            read_data_q <= rd_c;
            state       <= DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (busy_q && dispatch) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-addressed memory model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 4096;
  localparam int          L     = 2;
  localparam int          AW    = 12;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [AW-1:0] bram_addr;
  logic [3:0]    bram_we;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;
  logic          err_o;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .ADDR_BASE    (BASE),
    .DEPTH        (DEPTH),
    .READ_LATENCY (L)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .mem_bus   (bus),
    .bram_addr (bram_addr),
    .bram_we   (bram_we),
    .bram_din  (bram_din),
    .bram_dout (bram_dout),
    .err_o     (err_o)
  );

  always #5 clk_in = ~clk_in;

  // External BRAM with L cycles of read latency.
  logic [31:0] bmem [DEPTH] = '{default: '0};
  logic [31:0] pipe [L]     = '{default: '0};

  always @(posedge clk_in) begin
    for (int i = 0; i < 4; i++)
      if (bram_we[i]) bmem[bram_addr][i*8 +: 8] <= bram_din[i*8 +: 8];
    pipe[0] <= bmem[bram_addr];
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign bram_dout = pipe[L-1];

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  rmem [4*DEPTH] = '{default: '0};
  logic [31:0] exp_rd = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit legal_of(logic [31:0] a, logic [1:0] w);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= 4 * DEPTH) return 1'b0;
    case (w)
      2'd0:    return 1'b1;
      2'd1:    return a[0] == 1'b0;
      2'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Caller is #1 after a clock edge (or in a DONE cycle); returns in the DONE cycle.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [1:0] w, input logic [31:0] wd, input bit intrude);
    bit          legal, is_rd, done;
    int          nbytes, off, exp_busy, exp_err, nb, ne;
    logic [3:0]  exp_we, we_or;
    logic [31:0] addr_seen;
    legal    = legal_of(a, w);
    is_rd    = rd && !wr;
    nbytes   = 1 << w;
    off      = int'(a - BASE);
    exp_busy = (legal && is_rd) ? L + 2 : 2;
    exp_err  = ((!legal || (rd && wr)) ? 1 : 0) + (intrude ? 1 : 0);
    exp_we   = '0;
    if (legal && wr) begin
      for (int i = 0; i < nbytes; i++) begin
        exp_we[int'(a[1:0]) + i] = 1'b1;
        rmem[off + i] = wd[8*i +: 8];
      end
    end
    if (is_rd) begin
      exp_rd = '0;
      if (legal)
        for (int i = 0; i < nbytes; i++) exp_rd[8*i +: 8] = rmem[off + i];
    end

    bus.addr           = a;
    bus.mem_width      = mem_width_t'(w);
    bus.write_data     = wd;
    bus.dispatch_read  = rd;
    bus.dispatch_write = wr;
    nb = 0; ne = 0; we_or = '0; done = 1'b0; addr_seen = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.busy) nb++;
      if (c > 0) begin
        we_or |= bram_we;
        if (bram_we != 4'h0) addr_seen = 32'(bram_addr);
        if (err_o) ne++;
      end
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk_in);
      #1;
      bus.dispatch_read  = 1'b0;
      bus.dispatch_write = 1'b0;
      if (intrude && c == 1) begin
        bus.dispatch_write = 1'b1;
        bus.addr           = $urandom;
        bus.write_data     = $urandom;
      end
    end
    check_val("op_done", 32'(done), 32'd1);
    check_val("busy_cycles", nb, exp_busy);
    check_val("err_pulses", ne, exp_err);
    check_val("bram_we", 32'(we_or), 32'(exp_we));
    check_val("read_data", bus.read_data, exp_rd);
    if (legal && wr) check_val("bram_addr", addr_seen, 32'(off >> 2));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit          rd, wr, intr;
    logic [1:0]  w;
    logic [31:0] a;
    int          r;
    bus.dispatch_read  = 1'b0;
    bus.dispatch_write = 1'b0;
    bus.addr           = '0;
    bus.mem_width      = BYTE;
    bus.write_data     = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    #1;
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_read_data", bus.read_data, 32'd0);
    check_val("rst_bram_we", 32'(bram_we), 32'd0);
    check_val("rst_bram_addr", 32'(bram_addr), 32'd0);
    check_val("rst_bram_din", bram_din, 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);

    do_op(0, 1, 32'h10, 2'd2, 32'hDEAD_BEEF, 0);
    do_op(1, 0, 32'h10, 2'd2, 32'h0, 0);
    check_val("deadbeef", bus.read_data, 32'hDEAD_BEEF);
    do_op(0, 1, 32'h10, 2'd2, 32'h1122_3344, 0);
    do_op(0, 1, 32'h13, 2'd0, 32'h0000_00AB, 0);
    do_op(1, 0, 32'h10, 2'd2, 32'h0, 0);
    check_val("byte_merge", bus.read_data, 32'hAB22_3344);
    do_op(1, 0, 32'h13, 2'd0, 32'h0, 0);
    check_val("byte_read", bus.read_data, 32'h0000_00AB);
    idle(1);
    do_op(0, 1, 32'h22, 2'd1, 32'h0000_8001, 0);
    do_op(1, 0, 32'h22, 2'd1, 32'h0, 0);
    check_val("word_zext", bus.read_data, 32'h0000_8001);
    do_op(1, 0, 32'h02, 2'd2, 32'h0, 0);
    do_op(0, 1, 32'(4 * DEPTH), 2'd1, 32'h0000_1234, 0);
    do_op(1, 0, 32'h10, 2'd2, 32'h0, 1);
    do_op(1, 1, 32'h30, 2'd2, 32'h55AA_1234, 0);
    do_op(1, 0, 32'h30, 2'd2, 32'h0, 0);

    // Asynchronous reset in the middle of a read wait.
    idle(1);
    bus.addr = 32'h10; bus.mem_width = DWORD; bus.dispatch_read = 1'b1;
    idle(1);
    bus.dispatch_read = 1'b0;
    idle(1);
    #2 rst_in = 1'b1;
    #1;
    check_val("midrst_busy", 32'(bus.busy), 32'd0);
    check_val("midrst_read_data", bus.read_data, 32'd0);
    check_val("midrst_bram_we", 32'(bram_we), 32'd0);
    #1 rst_in = 1'b0;
    exp_rd = '0;
    idle(1);
    do_op(1, 0, 32'h10, 2'd2, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 19);
      rd = (r < 9) || (r >= 18);
      wr = (r >= 9);
      w  = 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      else if (r == 1) a = $urandom;
      else             a = 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << w) - 1);
      intr = rd && !wr && legal_of(a, w) && ($urandom_range(0, 3) == 0);
      do_op(rd, wr, a, w, $urandom, intr);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
